pc_sequencer: RTL

//   Owns the architectural PC and sequences fetch and execute for the RV32I core

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the RV32I core: owns the architectural PC and holds
// each fetched instruction stable until the datapath reports completion.
//
// state | meaning
// IDLE  | one cycle after reset release, nothing requested
// FETCH | imem_req high at PC, waiting for grant
// WAIT  | granted, waiting for read data
// EXEC  | instruction held and valid, waiting for exec_done
module pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] JalrTarget,
    input  logic            exec_done,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [31:0]     Instr,
    output logic            instr_valid,
    output logic            trap,
    output logic [XLEN-1:0] trap_epc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_req;
    logic            r_valid;
    logic            r_trap;
    logic [XLEN-1:0] r_epc;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;
    logic            w_misaligned;

    assign w_pc_plus4 = r_pc + XLEN'(4);

    // PCSrc 11 is reserved and behaves as sequential flow.
    always_comb begin
        w_pc_next = w_pc_plus4;
        case (PCSrc)
            2'b01:   w_pc_next = PCTarget;
            2'b10:   w_pc_next = {JalrTarget[XLEN-1:1], 1'b0};
            default: w_pc_next = w_pc_plus4;
        endcase
    end

    // Without the C extension any target with bit1 set is misaligned.
    assign w_misaligned = w_pc_next[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= NOP;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_trap  <= 1'b0;
            r_epc   <= '0;
        end else begin
            r_trap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    // rvalid without gnt is a stale response and is dropped.
                    if (imem_gnt) begin
                        r_req <= 1'b0;
                        if (imem_rvalid) begin
                            r_instr <= imem_rdata;
                            r_valid <= 1'b1;
                            r_state <= S_EXEC;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                        if (w_misaligned) begin
                            r_pc   <= TRAP_PC;
                            r_epc  <= r_pc;
                            r_trap <= 1'b1;
                        end else begin
                            r_pc <= w_pc_next;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign Instr       = r_instr;
    assign instr_valid = r_valid;
    assign trap        = r_trap;
    assign trap_epc    = r_epc;

endmodule
